piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter: DATA_W, default 8, parallel word width (>=2).
REQ-002 Parameter: LSB_FIRST, default 1, bit order (1 = bit 0 first, 0 = bit DATA_W-1 first).
REQ-003 Parameter: CNT_W, default 16, width of completed-word counter.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: arst_n  input  1  reset, synchronous, active-low (name kept for consistency; no asynchronous behaviour).
REQ-006 Port: par_data_i  input  DATA_W  parallel word to serialize.
REQ-007 Port: par_valid_i  input  1  par_data_i valid.
REQ-008 Port: par_ready_o  output  1  block can accept a word this cycle.
REQ-009 Port: ser_data_o  output  1  current serial bit.
REQ-010 Port: ser_valid_o  output  1  ser_data_o valid.
REQ-011 Port: ser_ready_i  input  1  downstream (SIPO) accepts current bit.
REQ-012 Port: ser_last_o  output  1  current bit is final bit of word.
REQ-013 Port: word_cnt_o  output  CNT_W  count of fully transmitted words.

Function
REQ-014 FSM states: IDLE, SHIFT.
REQ-015 Parallel handshake: word accepted on rising edge when par_valid_i && par_ready_o.
REQ-016 Serial handshake: bit consumed on rising edge when ser_valid_o && ser_ready_i.
REQ-017 IDLE: par_ready_o=1, ser_valid_o=0; on accept, load shift register, bit counter=0, go SHIFT.
REQ-018 SHIFT: ser_valid_o=1; ser_data_o = shift-register bit 0 (LSB_FIRST=1) or bit DATA_W-1 (LSB_FIRST=0).
REQ-019 SHIFT, bit consumed: shift register moves one position toward output end, bit counter +1.
REQ-020 ser_last_o=1 only in SHIFT with bit counter == DATA_W-1.
REQ-021 par_ready_o in SHIFT = ser_last_o && ser_ready_i (combinational; only permitted in-to-out path).
REQ-022 Last bit consumed with new word accepted same edge: load new word, counter=0, remain SHIFT; zero bubble cycles.
REQ-023 Last bit consumed, no new word: go IDLE.
REQ-024 ser_ready_i low in SHIFT: ser_data_o, ser_last_o, bit counter, shift register all hold.
REQ-025 par_data_i sampled only on accept; changes at other times have no effect.
REQ-026 word_cnt_o +1 on each edge where the last bit is consumed; wraps 2^CNT_W-1 -> 0.
REQ-027 Latency: first bit of an accepted word on ser_data_o the cycle after acceptance; word occupies exactly DATA_W cycles with ser_ready_i held high.
REQ-028 ser_ready_i ignored in IDLE; par_valid_i ignored when par_ready_o=0.

Reset
REQ-029 arst_n low at rising edge: state=IDLE, bit counter=0, shift register=0, word_cnt_o=0.
REQ-030 After reset edge: par_ready_o=1, ser_valid_o=0, ser_data_o=0, ser_last_o=0.
REQ-031 Reset mid-word discards remaining bits; partial word not counted in word_cnt_o.
REQ-032 Word presented while arst_n low is not accepted.

Verification
REQ-033 DATA_W=8, LSB_FIRST=1, ser_ready_i=1, send 0x1E -> ser_data_o 0,1,1,1,1,0,0,0 on 8 consecutive cycles, ser_last_o on 8th only, word_cnt_o=1.
REQ-034 LSB_FIRST=0, send 0x1E -> ser_data_o 0,0,0,1,1,1,1,0; ser_last_o on 8th.
REQ-035 Back-to-back 0x01 then 0x80 (par_valid_i held) -> 16 contiguous ser_valid_o cycles; 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1; par_ready_o high only on cycle 8; word_cnt_o=2.
REQ-036 Send 0x1E, drop ser_ready_i for 3 cycles while bit index 2 presented -> ser_data_o holds 1 for 4 cycles total, remaining bits unchanged, total 11 valid cycles.
REQ-037 Assert arst_n low after 4 bits of 0xFF -> next cycle ser_valid_o=0, par_ready_o=1, word_cnt_o=0; following 0x1E serializes intact from bit 0.
REQ-038 CNT_W=2, send 4 words -> word_cnt_o sequence 1,2,3,0.

Source files
------------

// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : piso_serializer_if
//  Purpose  : Parallel-in and serial-out handshake bundle for piso_serializer.
//             The slave modport is the serializer's view of the bus. The
//             master modport is the view of the surrounding logic, which
//             supplies words and consumes bits.
//  Revision : 1.0 - initial release
// ============================================================================
interface piso_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] par_data_i;
    logic              par_valid_i;
    logic              par_ready_o;
    logic              ser_data_o;
    logic              ser_valid_o;
    logic              ser_ready_i;
    logic              ser_last_o;

    modport slave (
        input  par_data_i,
        input  par_valid_i,
        output par_ready_o,
        output ser_data_o,
        output ser_valid_o,
        input  ser_ready_i,
        output ser_last_o
    );

    modport master (
        output par_data_i,
        output par_valid_i,
        input  par_ready_o,
        input  ser_data_o,
        input  ser_valid_o,
        output ser_ready_i,
        input  ser_last_o
    );
endinterface : piso_serializer_if
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : piso_serializer
//  Purpose  : Accepts a parallel word over a valid/ready handshake and emits
//             it one bit per consumed beat on a valid/ready serial stream.
//             The bit order is selectable. The next word can be loaded on
//             the same edge that consumes the last bit, so back-to-back words
//             stream without a gap. A wrapping counter records how many words
//             have completed.
//  Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int DATA_W    = 8,
    parameter int LSB_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  wire logic             clk,
    input  wire logic             arst_n,
    piso_serializer_if.slave      bus,
    output logic [CNT_W-1:0]      word_cnt_o
);

    localparam int                 c_BIT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [c_BIT_W-1:0] c_LAST_IDX = c_BIT_W'(DATA_W - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t              state_q,  state_d;
    logic [DATA_W-1:0]   shreg_q,  shreg_d;
    logic [c_BIT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]    wcnt_q,   wcnt_d;

    logic                w_shifting;
    logic                w_last;
    logic                w_out_bit;
    logic [DATA_W-1:0]   w_shifted;
    logic                w_accept;
    logic                w_consume;

    // Bit order only changes which end is presented and which way the register moves
    if (LSB_FIRST != 0) begin : g_lsb_first
        assign w_out_bit = shreg_q[0];
        assign w_shifted = {1'b0, shreg_q[DATA_W-1:1]};
    end else begin : g_msb_first
        assign w_out_bit = shreg_q[DATA_W-1];
        assign w_shifted = {shreg_q[DATA_W-2:0], 1'b0};
    end

    assign w_shifting = (state_q == S_SHIFT);
    assign w_last     = w_shifting && (bitcnt_q == c_LAST_IDX);

    // Ready while shifting is allowed only when the final bit leaves on this
    // edge. This is the single input-to-output combinational path.
    assign bus.par_ready_o = !w_shifting || (w_last && bus.ser_ready_i);
    assign bus.ser_valid_o = w_shifting;
    assign bus.ser_data_o  = w_shifting && w_out_bit;
    assign bus.ser_last_o  = w_last;
    assign word_cnt_o      = wcnt_q;

    assign w_accept  = bus.par_valid_i && bus.par_ready_o;
    assign w_consume = w_shifting && bus.ser_ready_i;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            wcnt_q   <= wcnt_d;
        end
    end

    // Next state: consume and shift first, then a same-edge load takes priority
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        wcnt_d   = wcnt_q;

        if (w_consume) begin
            shreg_d  = w_shifted;
            bitcnt_d = bitcnt_q + 1'b1;
            if (w_last) begin
                wcnt_d   = wcnt_q + 1'b1;
                bitcnt_d = '0;
                state_d  = S_IDLE;
            end
        end

        if (w_accept) begin
            shreg_d  = bus.par_data_i;
            bitcnt_d = '0;
            state_d  = S_SHIFT;
        end
    end

endmodule : piso_serializer
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piso_serializer
//  Purpose  : Directed self-checking bench for piso_serializer. It builds
//             three instances: the default build (A), an MSB-first build (B)
//             and a build with a 2-bit word counter (C).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    logic clk;
    logic arst_n;
    int   n_chk;
    int   n_fail;

    logic [15:0] cnt_a;
    logic [15:0] cnt_b;
    logic [1:0]  cnt_c;

    piso_serializer_if #(.DATA_W(8)) bus_a ();
    piso_serializer_if #(.DATA_W(8)) bus_b ();
    piso_serializer_if #(.DATA_W(8)) bus_c ();

    piso_serializer #(.DATA_W(8), .LSB_FIRST(1), .CNT_W(16)) dut_a (
        .clk        (clk),
        .arst_n     (arst_n),
        .bus        (bus_a),
        .word_cnt_o (cnt_a)
    );

    piso_serializer #(.DATA_W(8), .LSB_FIRST(0), .CNT_W(16)) dut_b (
        .clk        (clk),
        .arst_n     (arst_n),
        .bus        (bus_b),
        .word_cnt_o (cnt_b)
    );

    piso_serializer #(.DATA_W(8), .LSB_FIRST(1), .CNT_W(2)) dut_c (
        .clk        (clk),
        .arst_n     (arst_n),
        .bus        (bus_c),
        .word_cnt_o (cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-derived serial sequences
    int seq_lsb_1e [8]  = '{0, 1, 1, 1, 1, 0, 0, 0};
    int seq_msb_1e [8]  = '{0, 0, 0, 1, 1, 1, 1, 0};
    int seq_b2b   [16] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    int seq_stall [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    int rdy_stall [11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    int cnt_wrap  [4]  = '{1, 2, 3, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        arst_n = 1'b0;
        bus_a.par_data_i = '0; bus_a.par_valid_i = 1'b0; bus_a.ser_ready_i = 1'b1;
        bus_b.par_data_i = '0; bus_b.par_valid_i = 1'b0; bus_b.ser_ready_i = 1'b1;
        bus_c.par_data_i = '0; bus_c.par_valid_i = 1'b0; bus_c.ser_ready_i = 1'b1;

        // ---- reset state ----
        nxt(); nxt();
        smp();
        chk("rst_a_ready", 32'(bus_a.par_ready_o), 32'd1);
        chk("rst_a_valid", 32'(bus_a.ser_valid_o), 32'd0);
        chk("rst_a_data",  32'(bus_a.ser_data_o),  32'd0);
        chk("rst_a_last",  32'(bus_a.ser_last_o),  32'd0);
        chk("rst_a_cnt",   32'(cnt_a),             32'd0);
        chk("rst_b_valid", 32'(bus_b.ser_valid_o), 32'd0);
        chk("rst_c_cnt",   32'(cnt_c),             32'd0);
        nxt();
        arst_n = 1'b1;

        // ---- LSB-first single word 0x1E ----
        bus_a.par_data_i  = 8'h1E;
        bus_a.par_valid_i = 1'b1;
        smp();
        chk("a1_ready_idle", 32'(bus_a.par_ready_o), 32'd1);
        chk("a1_valid_idle", 32'(bus_a.ser_valid_o), 32'd0);
        nxt();
        bus_a.par_valid_i = 1'b0;
        bus_a.par_data_i  = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            smp();
            chk($sformatf("a1_valid[%0d]", i), 32'(bus_a.ser_valid_o), 32'd1);
            chk($sformatf("a1_data[%0d]", i),  32'(bus_a.ser_data_o),  32'(seq_lsb_1e[i]));
            chk($sformatf("a1_last[%0d]", i),  32'(bus_a.ser_last_o),  (i == 7) ? 32'd1 : 32'd0);
            nxt();
        end
        smp();
        chk("a1_valid_end", 32'(bus_a.ser_valid_o), 32'd0);
        chk("a1_cnt",       32'(cnt_a),             32'd1);
        nxt();

        // ---- back-to-back 0x01 then 0x80 ----
        bus_a.par_data_i  = 8'h01;
        bus_a.par_valid_i = 1'b1;
        nxt();
        bus_a.par_data_i = 8'h80;
        for (int i = 0; i < 16; i++) begin
            smp();
            chk($sformatf("b2b_valid[%0d]", i), 32'(bus_a.ser_valid_o), 32'd1);
            chk($sformatf("b2b_data[%0d]", i),  32'(bus_a.ser_data_o),  32'(seq_b2b[i]));
            chk($sformatf("b2b_last[%0d]", i),  32'(bus_a.ser_last_o),
                (i == 7 || i == 15) ? 32'd1 : 32'd0);
            if (i < 15)
                chk($sformatf("b2b_ready[%0d]", i), 32'(bus_a.par_ready_o), (i == 7) ? 32'd1 : 32'd0);
            nxt();
            if (i == 7) bus_a.par_valid_i = 1'b0;
        end
        smp();
        chk("b2b_valid_end", 32'(bus_a.ser_valid_o), 32'd0);
        chk("b2b_cnt",       32'(cnt_a),             32'd3);
        nxt();

        // ---- backpressure while bit 2 of 0x1E is presented ----
        bus_a.par_data_i  = 8'h1E;
        bus_a.par_valid_i = 1'b1;
        nxt();
        bus_a.par_valid_i = 1'b0;
        for (int i = 0; i < 11; i++) begin
            bus_a.ser_ready_i = (rdy_stall[i] != 0);
            smp();
            chk($sformatf("stall_valid[%0d]", i), 32'(bus_a.ser_valid_o), 32'd1);
            chk($sformatf("stall_data[%0d]", i),  32'(bus_a.ser_data_o),  32'(seq_stall[i]));
            chk($sformatf("stall_last[%0d]", i),  32'(bus_a.ser_last_o),  (i == 10) ? 32'd1 : 32'd0);
            nxt();
        end
        bus_a.ser_ready_i = 1'b1;
        smp();
        chk("stall_valid_end", 32'(bus_a.ser_valid_o), 32'd0);
        chk("stall_cnt",       32'(cnt_a),             32'd4);
        nxt();

        // ---- reset mid-word, word offered during reset is not taken ----
        bus_a.par_data_i  = 8'hFF;
        bus_a.par_valid_i = 1'b1;
        nxt();
        bus_a.par_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk($sformatf("mid_data[%0d]", i), 32'(bus_a.ser_data_o), 32'd1);
            nxt();
        end
        arst_n = 1'b0;
        bus_a.par_data_i  = 8'h1E;
        bus_a.par_valid_i = 1'b1;
        nxt();
        smp();
        chk("mid_rst_valid", 32'(bus_a.ser_valid_o), 32'd0);
        chk("mid_rst_ready", 32'(bus_a.par_ready_o), 32'd1);
        chk("mid_rst_cnt",   32'(cnt_a),             32'd0);
        chk("mid_rst_data",  32'(bus_a.ser_data_o),  32'd0);
        nxt();
        smp();
        chk("rst_hold_valid", 32'(bus_a.ser_valid_o), 32'd0);
        nxt();
        arst_n = 1'b1;
        smp();
        chk("post_rst_valid", 32'(bus_a.ser_valid_o), 32'd0);
        nxt();
        bus_a.par_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            smp();
            chk($sformatf("post_valid[%0d]", i), 32'(bus_a.ser_valid_o), 32'd1);
            chk($sformatf("post_data[%0d]", i),  32'(bus_a.ser_data_o),  32'(seq_lsb_1e[i]));
            chk($sformatf("post_last[%0d]", i),  32'(bus_a.ser_last_o),  (i == 7) ? 32'd1 : 32'd0);
            nxt();
        end
        smp();
        chk("post_cnt", 32'(cnt_a), 32'd1);
        nxt();

        // ---- MSB-first 0x1E ----
        bus_b.par_data_i  = 8'h1E;
        bus_b.par_valid_i = 1'b1;
        nxt();
        bus_b.par_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            smp();
            chk($sformatf("msb_data[%0d]", i), 32'(bus_b.ser_data_o), 32'(seq_msb_1e[i]));
            chk($sformatf("msb_last[%0d]", i), 32'(bus_b.ser_last_o), (i == 7) ? 32'd1 : 32'd0);
            nxt();
        end
        smp();
        chk("msb_valid_end", 32'(bus_b.ser_valid_o), 32'd0);
        chk("msb_cnt",       32'(cnt_b),             32'd1);
        nxt();

        // ---- 2-bit counter wrap over four streamed words ----
        bus_c.par_data_i  = 8'h5A;
        bus_c.par_valid_i = 1'b1;
        nxt();
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < 8; i++) begin
                if (w == 3 && i == 7) bus_c.par_valid_i = 1'b0;
                nxt();
            end
            smp();
            chk($sformatf("wrap_cnt[%0d]", w), 32'(cnt_c), 32'(cnt_wrap[w]));
        end
        chk("wrap_valid_end", 32'(bus_c.ser_valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_piso_serializer
`default_nettype wire
